// File: rtl/novacore_timer_sched.sv
// Shares one interval timer among NREQ requesters: each request is a one-shot timeout,
// granted round-robin, programmed over a write-only register bus, and answered with a done pulse.
module novacore_timer_sched #(
  parameter int          NREQ       = 4,
  parameter logic [15:0] CTRL_START = 16'h0005,
  parameter logic [15:0] CTRL_STOP  = 16'h0008
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   req_period,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [2:0]           m_address,
  output logic                 m_chipselect,
  output logic                 m_write_n,
  output logic [15:0]          m_writedata,
  input  logic                 timer_irq
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [3:0] INIT_STOP  = 4'd0;
  localparam logic [3:0] INIT_CLR   = 4'd1;
  localparam logic [3:0] IDLE       = 4'd2;
  localparam logic [3:0] WR_PL      = 4'd3;
  localparam logic [3:0] WR_PH      = 4'd4;
  localparam logic [3:0] SETTLE     = 4'd5;
  localparam logic [3:0] WR_CTRL    = 4'd6;
  localparam logic [3:0] WAIT_IRQ   = 4'd7;
  localparam logic [3:0] CLR_STATUS = 4'd8;
  localparam logic [3:0] DONE       = 4'd9;

  logic [3:0]      state;
  logic [NREQ-1:0] pending;
  logic [31:0]     period [NREQ];
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  cur_id;
  logic [31:0]     cur_period;

  logic            grant_found;
  logic [IDW-1:0]  grant_id;
  logic [NREQ-1:0] clr_mask;

  // Round-robin search starting one past the last requester served.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_found && pending[idx]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
    clr_mask = (state == IDLE && grant_found) ? (NREQ'(1) << grant_id) : '0;
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT_STOP;
      pending    <= '0;
      last_grant <= IDW'(NREQ - 1);
      cur_id     <= '0;
      cur_period <= '0;
      // NOTE: the period file is small and must read as zero after reset, so it is reset explicitly.
      for (int i = 0; i < NREQ; i++) period[i] <= '0;
    end else begin
      // A new request wins over the grant clear, so a re-request of the winner stays queued.
      pending <= (pending & ~clr_mask) | req;
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) period[i] <= req_period[i*32 +: 32];
      end

      case (state)
        INIT_STOP:  state <= INIT_CLR;
        INIT_CLR:   state <= IDLE;
        IDLE: begin
          if (grant_found) begin
            cur_id     <= grant_id;
            cur_period <= period[grant_id];
            state      <= (period[grant_id] == 32'd0) ? DONE : WR_PL;
          end
        end
        WR_PL:      state <= WR_PH;
        WR_PH:      state <= SETTLE;
        SETTLE:     state <= WR_CTRL;
        WR_CTRL:    state <= WAIT_IRQ;
        WAIT_IRQ:   if (timer_irq) state <= CLR_STATUS;
        CLR_STATUS: state <= DONE;
        DONE: begin
          last_grant <= cur_id;
          state      <= IDLE;
        end
        default:    state <= INIT_STOP;
      endcase
    end
  end

  // Bus and handshake outputs depend only on registered state (and reset holds them idle).
  always_comb begin
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_address    = 3'd0;
    m_writedata  = 16'h0000;
    if (!reset) begin
      case (state)
        INIT_STOP: begin
          m_chipselect = 1'b1; m_write_n = 1'b0; m_address = 3'd1; m_writedata = CTRL_STOP;
        end
        INIT_CLR, CLR_STATUS: begin
          m_chipselect = 1'b1; m_write_n = 1'b0; m_address = 3'd0; m_writedata = 16'h0000;
        end
        WR_PL: begin
          m_chipselect = 1'b1; m_write_n = 1'b0; m_address = 3'd2; m_writedata = cur_period[15:0];
        end
        WR_PH: begin
          m_chipselect = 1'b1; m_write_n = 1'b0; m_address = 3'd3; m_writedata = cur_period[31:16];
        end
        WR_CTRL: begin
          m_chipselect = 1'b1; m_write_n = 1'b0; m_address = 3'd1; m_writedata = CTRL_START;
        end
        default: ;
      endcase
    end
  end

  assign busy = reset || (state != IDLE);
  assign done = (!reset && state == DONE) ? (NREQ'(1) << cur_id) : '0;

endmodule

// File: tb/tb_novacore_timer_sched.sv
// Bench for novacore_timer_sched: a simple interval-timer slave model plus a round-robin
// service-order model; each scenario task checks done order, bus programming and timing.
module tb_novacore_timer_sched;

  localparam int          NREQ  = 4;
  localparam logic [15:0] START = 16'h0005;
  localparam logic [15:0] STOP  = 16'h0008;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*32-1:0] req_period;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [2:0]         m_address;
  logic               m_chipselect;
  logic               m_write_n;
  logic [15:0]        m_writedata;
  logic               timer_irq;

  novacore_timer_sched #(.NREQ(NREQ), .CTRL_START(START), .CTRL_STOP(STOP)) dut (
    .clk(clk), .reset(reset), .req(req), .req_period(req_period), .done(done),
    .busy(busy), .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write_n(m_write_n), .m_writedata(m_writedata), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [2:0] addr; logic [15:0] data; } wr_t;
  typedef struct { int cyc; logic [NREQ-1:0] vec; } done_t;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  wr_t   w_q[$];
  done_t done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Timer slave: a start write loads period+1; irq rises when that count runs out, clears on status write.
  logic [15:0] t_pl = 16'h0, t_ph = 16'h0;
  longint      t_cnt = 0;
  logic        t_run = 1'b0;
  logic        t_irq = 1'b0;
  logic        irq_inject = 1'b0;
  assign timer_irq = t_irq | irq_inject;

  always @(negedge clk) begin
    if (m_chipselect && !m_write_n) begin
      w_q.push_back('{cyc: cyc, addr: m_address, data: m_writedata});
      case (m_address)
        3'd0: t_irq <= 1'b0;
        3'd1: begin
          if (m_writedata[3]) t_run <= 1'b0;
          else if (m_writedata[2]) begin
            t_cnt <= longint'({t_ph, t_pl}) + 1;
            t_run <= 1'b1;
          end
        end
        3'd2: t_pl <= m_writedata;
        3'd3: t_ph <= m_writedata;
        default: ;
      endcase
    end else if (t_run) begin
      t_cnt <= t_cnt - 1;
      if (t_cnt == 1) begin
        t_irq <= 1'b1;
        t_run <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (done !== '0) done_q.push_back('{cyc: cyc, vec: done});
  end

  logic [31:0] stim_p [NREQ];
  int          model_last;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [NREQ-1:0] mask, output int rcyc);
    @(posedge clk); #1;
    req = mask;
    for (int i = 0; i < NREQ; i++) req_period[i*32 +: 32] = stim_p[i];
    rcyc = cyc;
    @(posedge clk); #1;
    req = '0;
    for (int i = 0; i < NREQ; i++) req_period[i*32 +: 32] = $urandom;
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] pend, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (pend[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Waits for the next done pulse and verifies it against one expected service.
  task automatic expect_service(input int id, input logic [31:0] p, input int budget,
                                output int first_wr, output int done_cyc);
    int n;
    done_t d;
    wr_t wl[$];
    logic [NREQ-1:0] exp_vec;
    logic [75:0] got_seq, exp_seq;
    n = 0; first_wr = -1; done_cyc = -1;
    while (done_q.size() == 0 && n < budget) begin tick(1); n++; end
    checks++;
    if (done_q.size() == 0) begin
      errors++;
      $display("FAIL svc_timeout id=%0d: no done pulse within %0d cycles", id, budget);
      return;
    end
    d = done_q.pop_front();
    done_cyc = d.cyc;
    exp_vec = NREQ'(1) << id;
    checks++;
    if (d.vec !== exp_vec) begin
      errors++;
      $display("FAIL svc_id: done=%b required %b", d.vec, exp_vec);
    end
    while (w_q.size() > 0 && w_q[0].cyc < d.cyc) wl.push_back(w_q.pop_front());
    checks++;
    if (p == 32'd0) begin
      if (wl.size() != 0) begin
        errors++;
        $display("FAIL svc_zero_writes id=%0d: %0d bus writes, required 0", id, wl.size());
      end
    end else if (wl.size() != 4) begin
      errors++;
      $display("FAIL svc_nwrites id=%0d: %0d bus writes, required 4", id, wl.size());
    end else begin
      first_wr = wl[0].cyc;
      got_seq = {wl[0].addr, wl[0].data, wl[1].addr, wl[1].data,
                 wl[2].addr, wl[2].data, wl[3].addr, wl[3].data};
      exp_seq = {3'd2, p[15:0], 3'd3, p[31:16], 3'd1, START, 3'd0, 16'h0000};
      checks++;
      if (got_seq !== exp_seq) begin
        errors++;
        $display("FAIL svc_writes id=%0d: got %h required %h", id, got_seq, exp_seq);
      end
      checks++;
      if (wl[1].cyc - wl[0].cyc != 1 || wl[2].cyc - wl[0].cyc != 3) begin
        errors++;
        $display("FAIL svc_prog_timing id=%0d: offsets %0d,%0d required 1,3",
                 id, wl[1].cyc - wl[0].cyc, wl[2].cyc - wl[0].cyc);
      end
      checks++;
      if (d.cyc - wl[2].cyc != int'(p) + 3 || wl[3].cyc != d.cyc - 1) begin
        errors++;
        $display("FAIL svc_count_timing id=%0d: start->done %0d required %0d, clr at %0d required %0d",
                 id, d.cyc - wl[2].cyc, int'(p) + 3, wl[3].cyc, d.cyc - 1);
      end
    end
  endtask

  task automatic expect_quiet(input string name, input int n);
    tick(n);
    checks++;
    if (done_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_quiet: extra dones=%0d busy=%b required 0,0", name, done_q.size(), busy);
    end
    done_q.delete();
    w_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    checks++;
    if (m_chipselect !== 1'b0 || m_write_n !== 1'b1 || m_address !== 3'd0 ||
        m_writedata !== 16'h0 || busy !== 1'b1 || done !== '0) begin
      errors++;
      $display("FAIL reset_hold: cs=%b wn=%b a=%0d d=%h busy=%b done=%b required 0 1 0 0000 1 0",
               m_chipselect, m_write_n, m_address, m_writedata, busy, done);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (m_chipselect !== 1'b1 || m_write_n !== 1'b0 || m_address !== 3'd1 || m_writedata !== STOP) begin
      errors++;
      $display("FAIL reset_init_stop: cs=%b wn=%b a=%0d d=%h required 1 0 1 %h",
               m_chipselect, m_write_n, m_address, m_writedata, STOP);
    end
    tick(1);
    checks++;
    if (m_chipselect !== 1'b1 || m_write_n !== 1'b0 || m_address !== 3'd0) begin
      errors++;
      $display("FAIL reset_init_clr: cs=%b wn=%b a=%0d required 1 0 0", m_chipselect, m_write_n, m_address);
    end
    tick(1);
    checks++;
    if (busy !== 1'b0 || m_chipselect !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b cs=%b required 0 0", busy, m_chipselect);
    end
    model_last = NREQ - 1;
    expect_quiet("reset", 2);
  endtask

  task automatic test_single();
    int rc, fw, dc;
    stim_p[1] = 32'h0001_0010;
    drive_req(4'b0010, rc);
    expect_service(1, 32'h0001_0010, 70000, fw, dc);
    checks++;
    if (fw != rc + 2) begin
      errors++;
      $display("FAIL single_grant_latency: first write cycle %0d required %0d", fw, rc + 2);
    end
    model_last = 1;
    expect_quiet("single", 4);
  endtask

  task automatic test_zero();
    int rc, fw, dc;
    stim_p[2] = 32'd0;
    drive_req(4'b0100, rc);
    expect_service(2, 32'd0, 20, fw, dc);
    checks++;
    if (dc != rc + 2) begin
      errors++;
      $display("FAIL zero_latency: done cycle %0d required %0d", dc, rc + 2);
    end
    model_last = 2;
    expect_quiet("zero", 4);
  endtask

  task automatic test_stray_irq();
    irq_inject = 1'b1;
    tick(6);
    checks++;
    if (busy !== 1'b0 || m_chipselect !== 1'b0) begin
      errors++;
      $display("FAIL stray_irq: busy=%b cs=%b required 0 0", busy, m_chipselect);
    end
    irq_inject = 1'b0;
    expect_quiet("stray_irq", 3);
  endtask

  task automatic test_round_robin();
    int rc, fw, dc;
    stim_p[0] = 32'd0;
    drive_req(4'b0001, rc);
    expect_service(0, 32'd0, 20, fw, dc);
    model_last = 0;
    expect_quiet("rr_setup", 3);
    stim_p[0] = 32'd7; stim_p[2] = 32'd0; stim_p[3] = 32'd12;
    drive_req(4'b1101, rc);
    expect_service(2, 32'd0, 30, fw, dc);
    expect_service(3, 32'd12, 60, fw, dc);
    expect_service(0, 32'd7, 60, fw, dc);
    model_last = 0;
    expect_quiet("rr", 6);
  endtask

  task automatic wait_start(input string name, input int budget);
    int n;
    n = 0;
    while (!(m_chipselect && !m_write_n && m_address == 3'd1 && m_writedata == START) && n < budget) begin
      tick(1); n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_start: no start write within %0d cycles", name, budget);
    end
  endtask

  task automatic test_requeue();
    int rc, fw, dc;
    stim_p[1] = 32'd20;
    drive_req(4'b0010, rc);
    wait_start("requeue", 20);
    tick(3);
    stim_p[1] = 32'd9;
    drive_req(4'b0010, rc);
    stim_p[3] = 32'd5;
    drive_req(4'b1000, rc);
    stim_p[3] = 32'd11;
    drive_req(4'b1000, rc);
    expect_service(1, 32'd20, 60, fw, dc);
    expect_service(3, 32'd11, 60, fw, dc);
    expect_service(1, 32'd9, 60, fw, dc);
    model_last = 1;
    expect_quiet("requeue", 6);
  endtask

  task automatic test_random();
    int rc, fw, dc, id;
    logic [NREQ-1:0] mask, pend;
    logic [31:0] mper [NREQ];
    for (int b = 0; b < 8; b++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++)
        stim_p[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 30));
      for (int i = 0; i < NREQ; i++) if (mask[i]) mper[i] = stim_p[i];
      pend = mask;
      drive_req(mask, rc);
      while (pend != '0) begin
        id = rr_pick(pend, model_last);
        pend[id] = 1'b0;
        expect_service(id, mper[id], 80, fw, dc);
        model_last = id;
      end
      expect_quiet("random", 4);
    end
  endtask

  task automatic test_reset_mid();
    int rc, fw, dc;
    stim_p[1] = 32'd50;
    drive_req(4'b0010, rc);
    wait_start("reset_mid", 20);
    stim_p[3] = 32'd4;
    drive_req(4'b1000, rc);
    tick(3);
    done_q.delete();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    #1;
    checks++;
    if (m_chipselect !== 1'b1 || m_write_n !== 1'b0 || m_address !== 3'd1 || m_writedata !== STOP) begin
      errors++;
      $display("FAIL reset_mid_init: cs=%b wn=%b a=%0d d=%h required 1 0 1 %h",
               m_chipselect, m_write_n, m_address, m_writedata, STOP);
    end
    model_last = NREQ - 1;
    expect_quiet("reset_mid", 100);
    stim_p[0] = 32'd3;
    drive_req(4'b0001, rc);
    expect_service(0, 32'd3, 40, fw, dc);
    model_last = 0;
    expect_quiet("reset_mid_recover", 4);
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    req_period = '0;
    for (int i = 0; i < NREQ; i++) stim_p[i] = '0;
    test_reset();
    test_single();
    test_zero();
    test_stray_irq();
    test_round_robin();
    test_requeue();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/novacore_timer_sched.md
NOVACORE_TIMER_SCHED -- requirements
Module: novacore_timer_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters sharing one interval timer (range 2..8).
REQ-002 The block SHALL have parameter CTRL_START, default 16'h0005, meaning the control word that starts the timer (START=bit2, ITO=bit0, CONT=0).
REQ-003 The block SHALL have parameter CTRL_STOP, default 16'h0008, meaning the control word that stops the timer (STOP=bit3, ITO=0).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock shared with the timer slave.
REQ-005 The block SHALL have port reset, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port req, input, NREQ bits: a one-cycle pulse per requester asking for a one-shot timeout.
REQ-007 The block SHALL have port req_period, input, NREQ*32 bits: the timeout in clocks, slice i belonging to requester i and sampled with req[i].
REQ-008 The block SHALL have port done, output, NREQ bits: a one-cycle pulse to the requester whose timeout expired.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The block SHALL have port m_address, output, 3 bits: the timer register index (0 status, 1 control, 2 period_l, 3 period_h).
REQ-011 The block SHALL have port m_chipselect, output, 1 bit, and port m_write_n, output, 1 bit (active low); each write completes in one cycle and there is no waitrequest.
REQ-012 The block SHALL have port m_writedata, output, 16 bits: the timer write data.
REQ-013 The block SHALL have port timer_irq, input, 1 bit: the timer interrupt, which is level-high until status is written.

Function
REQ-014 For each requester i, a pending[i] flag and a 32-bit period[i] register SHALL be loaded on a req[i] pulse; a repeat pulse while pending overwrites period[i].
REQ-015 A req[i] pulse for the requester currently in service SHALL set pending[i] and queue a new timeout; the in-service operation is unaffected.
REQ-016 The FSM states SHALL be: INIT_STOP, INIT_CLR, IDLE, WR_PL, WR_PH, SETTLE, WR_CTRL, WAIT_IRQ, CLR_STATUS, DONE.
REQ-017 INIT_STOP SHALL write CTRL_STOP to address 1 and go to INIT_CLR; INIT_CLR SHALL write any data to address 0 and go to IDLE.
REQ-018 In IDLE with any pending bit set, the block SHALL pick a winner by round-robin (search starts at last_grant+1 mod NREQ), clear that pending bit, latch cur_id and cur_period, and go to WR_PL; otherwise it stays in IDLE.
REQ-019 A req pulse arriving in the same IDLE cycle SHALL be eligible from the next cycle only.
REQ-020 If cur_period==0, the block SHALL go from IDLE directly to DONE with no bus writes.
REQ-021 WR_PL SHALL write cur_period[15:0] to address 2; WR_PH SHALL write cur_period[31:16] to address 3.
REQ-022 SETTLE SHALL be one idle cycle with no bus access, letting the timer's force-reload take effect.
REQ-023 WR_CTRL SHALL write CTRL_START to address 1.
REQ-024 WAIT_IRQ SHALL hold until timer_irq==1, then go to CLR_STATUS; CLR_STATUS SHALL write 16'h0000 to address 0.
REQ-025 DONE SHALL drive done[cur_id]=1 for exactly one cycle, update last_grant=cur_id, and go to IDLE.
REQ-026 m_chipselect=1 and m_write_n=0 SHALL occur only in INIT_STOP, INIT_CLR, WR_PL, WR_PH, WR_CTRL and CLR_STATUS.
REQ-027 In all other states, m_chipselect=0, m_write_n=1, m_address=0 and m_writedata=0.
REQ-028 Bus outputs SHALL be decoded from the state register, with no combinational path from req or timer_irq.
REQ-029 Nonzero-period latency from the IDLE grant edge to done SHALL be: 4 cycles of programming, then the timer count (period+1 clocks from the start write), then CLR_STATUS, then DONE.
REQ-030 timer_irq sampled high outside WAIT_IRQ SHALL be ignored; it is cleared only via CLR_STATUS or INIT_CLR.

Reset
REQ-031 While reset==1, the block SHALL set state=INIT_STOP, pending=0, period[*]=0, last_grant=NREQ-1, done=0 and busy=1.
REQ-032 While reset==1, bus outputs SHALL be idle (m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0).
REQ-033 Reset asserted mid-operation SHALL abandon the in-service request with no done pulse.
REQ-034 The INIT_STOP/INIT_CLR sequence after reset SHALL stop and clear a timer left running.

Verification
REQ-035 Reset release -> cycle 1: write addr1 data 0008; cycle 2: write addr0; cycle 3: busy=0.
REQ-036 req[1] with period 32'h0001_0010 in idle -> writes addr2=0010, addr3=0001, one gap cycle, addr1=0005; irq after the timer count; write addr0; done[1] pulses once.
REQ-037 req[0], req[2] and req[3] pulsed in the same cycle with last_grant=0 -> service order 2, 3, 0, with exactly one done pulse each.
REQ-038 req[2] with period 0 -> done[2] pulses 2 cycles after the request with no bus writes.
REQ-039 req[1] pulsed again during its own WAIT_IRQ -> two done[1] pulses, the second after a full new programming sequence.
REQ-040 reset pulsed during WAIT_IRQ -> no done pulse, pending cleared, INIT_STOP write seen on the first cycle after reset release.
